io_device_hub: RTL and testbench
================================

IO_DEVICE_HUB -- requirements
Module: io_device_hub

Interface
REQ-001 Parameter CHANNELS, default 4; number of device channels; the block SHALL be verified at 4 only.
REQ-002 Parameter WIDTH, default 32; bits per channel word; channel c occupies bus bits [WIDTH*c+WIDTH-1 : WIDTH*c].
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_data  input  128  device-side word per channel (switches or keypad).
REQ-006 key_valid  input  4  per-channel one-cycle offer of key_data.
REQ-007 key_ready  output  4  per-channel: input buffer not full.
REQ-008 dev_in  output  128  word presented to the processor per channel.
REQ-009 enter_in  output  4  per-channel: dev_in slice valid.
REQ-010 in_ack  input  4  per-channel one-cycle pulse: processor consumed the dev_in slice.
REQ-011 dev_out  input  128  processor output word per channel.
REQ-012 enter_out  input  4  per-channel processor output strobe (level; rising edge is the event).
REQ-013 disp_data  output  128  latched display word per channel.
REQ-014 disp_valid  output  4  per-channel: at least one word captured since reset.
REQ-015 disp_update  output  4  per-channel one-cycle pulse on each capture.
REQ-016 overrun  output  4  per-channel sticky flag: key word dropped.
REQ-017 ovr_clr  input  4  per-channel overrun clear.

Function -- input path (device to processor)
REQ-018 Each channel SHALL own an independent 2-entry FIFO with state EMPTY, ONE, FULL.
REQ-019 key_ready[c] SHALL be 1 in EMPTY and ONE, 0 in FULL (combinational from state).
REQ-020 Push: key_valid[c]=1 and key_ready[c]=1 at edge N stores key_data slice; enter_in[c] and dev_in slice SHALL reflect it from edge N onward (1-cycle latency).
REQ-021 enter_in[c] SHALL be 1 in ONE and FULL; dev_in slice SHALL equal the head entry, and 0 in EMPTY.
REQ-022 Pop: in_ack[c]=1 in ONE or FULL removes the head; in FULL the second entry becomes head on the same edge.
REQ-023 in_ack[c] in EMPTY SHALL be ignored; state unchanged.
REQ-024 Simultaneous push and pop in ONE: state stays ONE; the new word becomes head.
REQ-025 Push and pop in EMPTY: word is stored, ack is ignored; next state ONE.
REQ-026 key_valid[c]=1 in FULL (even with in_ack[c]=1 the same cycle) SHALL drop the word and set overrun[c] on that edge; the pop still occurs.
REQ-027 ovr_clr[c] SHALL clear overrun[c]; a simultaneous new overrun event wins (flag stays 1).
REQ-028 Channels SHALL NOT interact; order within a channel is strictly FIFO.

Function -- output path (processor to device)
REQ-029 A 4-bit register SHALL hold the previous enter_out; a rising edge on enter_out[c] SHALL be detected as enter_out[c]=1 and prev[c]=0.
REQ-030 On detection at edge N, the dev_out slice sampled at N SHALL load disp_data slice, set disp_valid[c], and drive disp_update[c]=1 for exactly the cycle following N.
REQ-031 enter_out held high SHALL produce a single capture; a new capture requires a low cycle.
REQ-032 disp_data slice SHALL hold its value between captures regardless of dev_out changes.

Reset
REQ-033 reset=1 at an edge SHALL force all FIFOs to EMPTY, dev_in=0, enter_in=0, disp_data=0, disp_valid=0, disp_update=0, overrun=0; key_ready SHALL read 4'b1111 after reset.
REQ-034 During reset the enter_out history register SHALL load the current enter_out, so a strobe held high through reset SHALL NOT cause a capture.
REQ-035 Reset SHALL take priority over every push, pop, capture and clear in the same cycle; buffered words are discarded.

Verification
REQ-036 Push 0xA5A5_0001 on ch0 -> next cycle enter_in=4'b0001, dev_in[31:0]=0xA5A5_0001; in_ack[0] -> enter_in[0]=0, dev_in[31:0]=0.
REQ-037 Push 0x11, 0x22, 0x33 on ch2 without ack -> key_ready[2]=0 after the second push, overrun[2]=1; two acks yield 0x11 then 0x22; ovr_clr[2] -> overrun[2]=0.
REQ-038 Ch1 in ONE holding 0x5; push 0x6 with in_ack[1] the same cycle -> state ONE, dev_in[63:32]=0x6.
REQ-039 dev_out[127:96]=0xDEAD_BEEF, enter_out[3] raised for 3 cycles -> one disp_update[3] pulse, disp_data[127:96]=0xDEAD_BEEF; change dev_out afterwards -> disp_data unchanged.
REQ-040 Both FIFOs of ch0/ch1 FULL, enter_out[0] high, assert reset -> all outputs at reset values, key_ready=4'b1111, no disp_update after reset release.

Source files
------------

// File: rtl/io_device_hub.sv
// Multi-channel I/O hub: per-channel 2-deep key FIFO toward the processor and
// an edge-triggered display latch for each processor output word.
module io_device_hub #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] key_data,
  input  logic [CHANNELS-1:0]       key_valid,
  output logic [CHANNELS-1:0]       key_ready,
  output logic [CHANNELS*WIDTH-1:0] dev_in,
  output logic [CHANNELS-1:0]       enter_in,
  input  logic [CHANNELS-1:0]       in_ack,
  input  logic [CHANNELS*WIDTH-1:0] dev_out,
  input  logic [CHANNELS-1:0]       enter_out,
  output logic [CHANNELS*WIDTH-1:0] disp_data,
  output logic [CHANNELS-1:0]       disp_valid,
  output logic [CHANNELS-1:0]       disp_update,
  output logic [CHANNELS-1:0]       overrun,
  input  logic [CHANNELS-1:0]       ovr_clr
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [CHANNELS-1:0] enter_prev;
  logic [CHANNELS-1:0] enter_rise;

  // The history register also loads during reset, so a strobe held high
  // through reset is treated as already seen.
  always_ff @(posedge clk) begin
    enter_prev <= enter_out;
  end

  assign enter_rise = enter_out & ~enter_prev;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [1:0]       state;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [WIDTH-1:0] word;
    logic             push;
    logic             pop;
    logic             drop;

    assign word = key_data[WIDTH*c +: WIDTH];
    assign push = key_valid[c] && (state != ST_FULL);
    assign drop = key_valid[c] && (state == ST_FULL);
    assign pop  = in_ack[c] && (state != ST_EMPTY);

    assign key_ready[c]             = (state != ST_FULL);
    assign enter_in[c]              = (state == ST_ONE) || (state == ST_FULL);
    assign dev_in[WIDTH*c +: WIDTH] = enter_in[c] ? head : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
      if (reset) begin
        state <= ST_EMPTY;
      end else begin
        case (state)
          ST_EMPTY: if (push) state <= ST_ONE;
          ST_ONE: begin
            if (push && !pop)      state <= ST_FULL;
            else if (pop && !push) state <= ST_EMPTY;
          end
          ST_FULL:  if (pop) state <= ST_ONE;
          default:  state <= ST_EMPTY;
        endcase
      end
    end

    // NOTE: the FIFO storage has no reset; its contents are only visible
    // through dev_in when the state says an entry is valid.
    always_ff @(posedge clk) begin
      case (state)
        ST_EMPTY: if (push) head <= word;
        ST_ONE: begin
          if (push && pop) head <= word;
          else if (push)   tail <= word;
        end
        ST_FULL:  if (pop) head <= tail;
        default: ;
      endcase
    end

    // A fresh drop outranks a clear arriving on the same edge.
    always_ff @(posedge clk) begin
      if (reset)           overrun[c] <= 1'b0;
      else if (drop)       overrun[c] <= 1'b1;
      else if (ovr_clr[c]) overrun[c] <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        disp_data[WIDTH*c +: WIDTH] <= '0;
        disp_valid[c]               <= 1'b0;
        disp_update[c]              <= 1'b0;
      end else begin
        disp_update[c] <= enter_rise[c];
        if (enter_rise[c]) begin
          disp_data[WIDTH*c +: WIDTH] <= dev_out[WIDTH*c +: WIDTH];
          disp_valid[c]               <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_device_hub.sv
// Self-checking bench for io_device_hub: directed scenarios then random
// traffic, compared against a queue-based reference model.
module tb_io_device_hub;

  localparam int CH = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH*W-1:0] key_data;
  logic [CH-1:0]   key_valid;
  logic [CH-1:0]   key_ready;
  logic [CH*W-1:0] dev_in;
  logic [CH-1:0]   enter_in;
  logic [CH-1:0]   in_ack;
  logic [CH*W-1:0] dev_out;
  logic [CH-1:0]   enter_out;
  logic [CH*W-1:0] disp_data;
  logic [CH-1:0]   disp_valid;
  logic [CH-1:0]   disp_update;
  logic [CH-1:0]   overrun;
  logic [CH-1:0]   ovr_clr;

  io_device_hub #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
    .dev_in(dev_in), .enter_in(enter_in), .in_ack(in_ack),
    .dev_out(dev_out), .enter_out(enter_out),
    .disp_data(disp_data), .disp_valid(disp_valid), .disp_update(disp_update),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a bounded queue per channel plus display bookkeeping.
  logic [W-1:0] mq [CH][$];
  logic         m_ovr  [CH];
  logic [W-1:0] m_disp [CH];
  logic         m_dval [CH];
  logic         m_upd  [CH];
  logic         m_prev [CH];

  task automatic check(input string tag, input logic [CH*W-1:0] obs, input logic [CH*W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      logic         full;
      logic         rise;
      logic [W-1:0] w;
      w = key_data[c*W +: W];
      if (reset) begin
        mq[c].delete();
        m_ovr[c]  = 1'b0;
        m_disp[c] = '0;
        m_dval[c] = 1'b0;
        m_upd[c]  = 1'b0;
        m_prev[c] = enter_out[c];
      end else begin
        full = (mq[c].size() == 2);
        if (in_ack[c] && mq[c].size() > 0) void'(mq[c].pop_front());
        if (key_valid[c] && !full) mq[c].push_back(w);
        if (key_valid[c] && full) m_ovr[c] = 1'b1;
        else if (ovr_clr[c])      m_ovr[c] = 1'b0;
        rise = enter_out[c] && !m_prev[c];
        m_upd[c] = rise;
        if (rise) begin
          m_disp[c] = dev_out[c*W +: W];
          m_dval[c] = 1'b1;
        end
        m_prev[c] = enter_out[c];
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [CH*W-1:0] e_dev;
    logic [CH*W-1:0] e_disp;
    logic [CH-1:0]   e_rdy, e_ent, e_dval, e_upd, e_ovr;
    for (int c = 0; c < CH; c++) begin
      e_rdy[c]        = (mq[c].size() < 2);
      e_ent[c]        = (mq[c].size() > 0);
      e_dev[c*W +: W] = (mq[c].size() > 0) ? mq[c][0] : '0;
      e_disp[c*W +: W] = m_disp[c];
      e_dval[c]       = m_dval[c];
      e_upd[c]        = m_upd[c];
      e_ovr[c]        = m_ovr[c];
    end
    check({tag, ".key_ready"},   key_ready,   e_rdy);
    check({tag, ".enter_in"},    enter_in,    e_ent);
    check({tag, ".dev_in"},      dev_in,      e_dev);
    check({tag, ".disp_data"},   disp_data,   e_disp);
    check({tag, ".disp_valid"},  disp_valid,  e_dval);
    check({tag, ".disp_update"}, disp_update, e_upd);
    check({tag, ".overrun"},     overrun,     e_ovr);
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic clear_pulses();
    key_valid = '0;
    in_ack    = '0;
    ovr_clr   = '0;
  endtask

  int pulses;

  initial begin
    reset = 1'b1; key_data = '0; key_valid = '0; in_ack = '0;
    dev_out = '0; enter_out = '0; ovr_clr = '0;
    for (int c = 0; c < CH; c++) m_prev[c] = 1'b0;

    tick("reset0");
    tick("reset1");
    reset = 1'b0;
    check("reset_key_ready", key_ready, 4'b1111);
    check("reset_enter_in", enter_in, 4'b0000);

    // Single push then ack on channel 0
    key_data[31:0] = 32'hA5A5_0001; key_valid = 4'b0001;
    tick("push_ch0");
    clear_pulses();
    check("ch0_enter_in", enter_in, 4'b0001);
    check("ch0_dev_in", dev_in[31:0], 32'hA5A5_0001);
    in_ack = 4'b0001;
    tick("ack_ch0");
    clear_pulses();
    check("ch0_empty_enter", enter_in, 4'b0000);
    check("ch0_empty_dev", dev_in[31:0], 32'h0);

    // Fill channel 2 and overrun it
    key_valid = 4'b0100;
    key_data[95:64] = 32'h11; tick("ch2_p1");
    key_data[95:64] = 32'h22; tick("ch2_p2");
    check("ch2_not_ready", key_ready[2], 1'b0);
    key_data[95:64] = 32'h33; tick("ch2_p3");
    clear_pulses();
    check("ch2_overrun", overrun[2], 1'b1);
    check("ch2_head1", dev_in[95:64], 32'h11);
    in_ack = 4'b0100; tick("ch2_a1");
    check("ch2_head2", dev_in[95:64], 32'h22);
    tick("ch2_a2");
    clear_pulses();
    check("ch2_drained", enter_in[2], 1'b0);
    ovr_clr = 4'b0100; tick("ch2_clr");
    clear_pulses();
    check("ch2_ovr_cleared", overrun[2], 1'b0);

    // Push and pop together while holding one entry on channel 1
    key_data[63:32] = 32'h5; key_valid = 4'b0010; tick("ch1_p5");
    key_data[63:32] = 32'h6; in_ack = 4'b0010; tick("ch1_pp6");
    clear_pulses();
    check("ch1_head6", dev_in[63:32], 32'h6);
    check("ch1_still_one", {enter_in[1], key_ready[1]}, 2'b11);
    in_ack = 4'b0010; tick("ch1_drain"); clear_pulses();

    // Overrun clear collides with a new drop: flag stays set
    key_valid = 4'b0001; key_data[31:0] = 32'h1; tick("ch0_f1");
    key_data[31:0] = 32'h2; tick("ch0_f2");
    key_data[31:0] = 32'h3; ovr_clr = 4'b0001; tick("ch0_drop_clr");
    clear_pulses();
    check("ch0_ovr_wins", overrun[0], 1'b1);
    ovr_clr = 4'b0001; in_ack = 4'b0001; tick("ch0_clr"); tick("ch0_a2");
    clear_pulses();

    // Display capture on channel 3, strobe held for three cycles
    dev_out[127:96] = 32'hDEAD_BEEF; enter_out = 4'b1000;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick("ch3_hold");
      if (disp_update[3]) pulses++;
    end
    enter_out = 4'b0000;
    tick("ch3_low");
    if (disp_update[3]) pulses++;
    check("ch3_one_pulse", pulses, 1);
    check("ch3_disp", disp_data[127:96], 32'hDEAD_BEEF);
    dev_out[127:96] = 32'h1234_5678;
    tick("ch3_hold_val");
    check("ch3_disp_kept", disp_data[127:96], 32'hDEAD_BEEF);
    check("ch3_valid", disp_valid[3], 1'b1);

    // Reset with ch0/ch1 full and a strobe held through reset
    key_valid = 4'b0011; key_data[63:0] = 64'h0000_00B1_0000_00A1; tick("fill1");
    key_data[63:0] = 64'h0000_00B2_0000_00A2; tick("fill2");
    clear_pulses();
    check("full_ready", key_ready, 4'b1100);
    enter_out = 4'b0001; reset = 1'b1; key_valid = 4'b0011; in_ack = 4'b0011;
    tick("rst_full");
    reset = 1'b0; clear_pulses();
    check("rst_ready", key_ready, 4'b1111);
    check("rst_dev_in", dev_in, '0);
    check("rst_disp", {disp_valid, overrun}, 8'h00);
    tick("post_rst1");
    tick("post_rst2");
    check("post_rst_no_update", disp_update, 4'b0000);
    enter_out = 4'b0000;
    tick("post_rst3");

    // Randomised traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++) begin
        key_data[c*W +: W] = $urandom;
        dev_out[c*W +: W]  = $urandom;
      end
      key_valid = 4'($urandom);
      in_ack    = 4'($urandom);
      ovr_clr   = 4'($urandom) & 4'($urandom) & 4'($urandom);
      enter_out = enter_out ^ (4'($urandom) & 4'($urandom));
      reset     = ($urandom_range(0, 63) == 0);
      tick("rand");
    end
    reset = 1'b0;
    clear_pulses();
    tick("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
